// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_ctrl
//  Description : Run/step/halt controller for a small CPU core. Loads the
//                instruction memory from a valid/ready word stream, then
//                gates the CPU update enable under run, single-step,
//                breakpoint, halt request and cycle-limit control.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset           clock, asynchronous active-high reset
//    load_start           begin a load session (load_count words, 0 = full)
//    load_valid/_data     load word source; load_ready is the sink side
//    run_req/step_req     run and single-step requests (level sampled)
//    halt_req             stop request (aborts LOAD, stops RUN/STEP)
//    pc, bp_en, bp_pc     CPU program counter and breakpoint match
//    cycle_limit          enabled cycles per run, 0 = unlimited
//    imem_we/addr/wdata   instruction memory write port
//    cpu_en, cpu_reset    CPU update enable and CPU reset request
//    state                IDLE=0 LOAD=1 RUN=2 STEP=3 HALT=4
//    cycle_count          enabled cycles since the last RUN entry
//    done, halt_cause     halt pulse and reason (0 none/step, 1 halt_req,
//                         2 cycle limit, 3 breakpoint)
// ============================================================================
module cpu_run_ctrl #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_pc,
  input  logic [CNT_W-1:0]  cycle_limit,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_en,
  output logic              cpu_reset,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              done,
  output logic [1:0]        halt_cause
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_BP    = 2'd3;

  state_t              state_q,       state_d;
  logic [ADDR_W-1:0]   idx_q,         idx_d;        // next word index in LOAD
  logic [ADDR_W-1:0]   last_q,        last_d;       // index of final word
  logic [ADDR_W-1:0]   addr_q,        addr_d;       // last written address
  logic                first_q,       first_d;      // first RUN cycle flag
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                done_q,        done_d;
  logic [1:0]          cause_q,       cause_d;

  logic                load_ready_c;
  logic                imem_we_c;
  logic                cpu_en_c;

  logic                bp_hit;
  logic                limit_on;
  logic                at_limit;
  logic                last_enabled;
  logic [CNT_W-1:0]    cnt_inc;

  // Breakpoint is masked on the first RUN cycle so a run can leave a
  // breakpoint address it is currently parked on.
  assign bp_hit       = bp_en && (pc == bp_pc) && !first_q;
  assign limit_on     = (cycle_limit != '0);
  // at_limit only matters if cycle_limit is lowered below the count mid-run.
  assign at_limit     = limit_on && (cycle_count_q >= cycle_limit);
  assign last_enabled = limit_on && (cycle_count_q == cycle_limit - CNT_W'(1));
  assign cnt_inc      = (cycle_count_q == '1) ? cycle_count_q
                                              : cycle_count_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    addr_d        = addr_q;
    first_d       = first_q;
    cycle_count_d = cycle_count_q;
    cause_d       = cause_q;
    load_ready_c  = (state_q == ST_LOAD);
    imem_we_c     = 1'b0;
    cpu_en_c      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          // count 0 wraps to the all-ones index, i.e. a full memory load
          last_d  = load_count - ADDR_W'(1);
        end else if (run_req) begin
          state_d       = ST_RUN;
          cycle_count_d = '0;
          first_d       = 1'b1;
          cause_d       = CAUSE_NONE;
        end else if (step_req) begin
          state_d = ST_STEP;
          cause_d = CAUSE_NONE;
        end
      end

      ST_LOAD: begin
        if (halt_req) begin
          // abort: nothing is written in this cycle
          state_d = ST_IDLE;
        end else if (load_valid) begin
          imem_we_c = 1'b1;
          addr_d    = idx_q;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == last_q) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        first_d = 1'b0;
        if (halt_req) begin
          state_d = ST_HALT;
          cause_d = CAUSE_HALT;
        end else if (bp_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BP;
        end else if (at_limit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_LIMIT;
        end else begin
          cpu_en_c      = 1'b1;
          cycle_count_d = cnt_inc;
          if (last_enabled) begin
            state_d = ST_HALT;
            cause_d = CAUSE_LIMIT;
          end
        end
      end

      ST_STEP: begin
        state_d = ST_HALT;
        if (halt_req) begin
          cause_d = CAUSE_HALT;
        end else begin
          cpu_en_c      = 1'b1;
          cycle_count_d = cnt_inc;
          cause_d       = CAUSE_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = ((state_q == ST_RUN) || (state_q == ST_STEP)) && (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      last_q        <= '0;
      addr_q        <= '0;
      first_q       <= 1'b0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      cause_q       <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      first_q       <= first_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      cause_q       <= cause_d;
    end
  end

  assign load_ready  = load_ready_c;
  assign imem_we     = imem_we_c;
  // During LOAD the address tracks the word being offered; otherwise it
  // holds the address of the last word actually written.
  assign imem_addr   = (state_q == ST_LOAD) ? idx_q : addr_q;
  assign imem_wdata  = load_data;
  assign cpu_en      = cpu_en_c;
  assign cpu_reset   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign state       = state_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign halt_cause  = cause_q;

endmodule
`default_nettype wire
